// File: rtl/vending_machine_gen2_if.sv
// Front-end / actuator bundle for the vending controller.
// The controller takes the slave side; the keypad, coin acceptor and actuators take the master side.
interface vending_machine_gen2_if #(
  parameter int PW      = 3,
  parameter int CW      = 3,
  parameter int MONEY_W = 16
);
  logic [PW-1:0]      i_product_code;
  logic               i_product_strobe;
  logic [CW-1:0]      i_currency_code;
  logic               i_currency_strobe;
  logic               i_cancel;
  logic               o_busy;
  logic               o_ready_to_receive;
  logic [MONEY_W-1:0] o_credit;
  logic [PW-1:0]      o_product;
  logic [CW-1:0]      o_change;
  logic               o_change_strobe;
  logic               o_no_change;
  logic               o_give_strobe;
  logic               o_sold_out;

  modport master (
    output i_product_code, i_product_strobe, i_currency_code, i_currency_strobe, i_cancel,
    input  o_busy, o_ready_to_receive, o_credit, o_product, o_change,
           o_change_strobe, o_no_change, o_give_strobe, o_sold_out
  );

  modport slave (
    input  i_product_code, i_product_strobe, i_currency_code, i_currency_strobe, i_cancel,
    output o_busy, o_ready_to_receive, o_credit, o_product, o_change,
           o_change_strobe, o_no_change, o_give_strobe, o_sold_out
  );
endinterface

// File: rtl/vending_machine_gen2.sv
// Vending controller: per-product stock, per-denomination coin inventory, and greedy
// change paid out one coin per cycle, with cancel/refund and sold-out rejection.
module vending_machine_gen2 #(
  parameter int N_PRODUCTS    = 8,
  parameter int N_COINS       = 8,
  parameter int MONEY_W       = 16,
  parameter int COUNT_W       = 8,
  parameter int INIT_COIN_CNT = 100,
  parameter int INIT_STOCK    = 10,
  parameter logic [N_COINS*MONEY_W-1:0] COIN_TABLE = {
    MONEY_W'(500), MONEY_W'(200), MONEY_W'(100), MONEY_W'(50),
    MONEY_W'(25),  MONEY_W'(10),  MONEY_W'(5),   MONEY_W'(1)},
  parameter logic [N_PRODUCTS*MONEY_W-1:0] PRICE_TABLE = {
    MONEY_W'(450), MONEY_W'(400), MONEY_W'(350), MONEY_W'(300),
    MONEY_W'(250), MONEY_W'(200), MONEY_W'(150), MONEY_W'(100)},
  localparam int PW = $clog2(N_PRODUCTS),
  localparam int CW = $clog2(N_COINS)
) (
  input  logic                   clk,
  input  logic                   i_rst_n,
  vending_machine_gen2_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_EVAL, S_CHANGE, S_VEND, S_DONE
  } state_t;

  state_t             r_state;
  logic [COUNT_W-1:0] r_stock [N_PRODUCTS];
  logic [COUNT_W-1:0] r_inv   [N_COINS];
  logic [MONEY_W-1:0] r_credit;
  logic [MONEY_W-1:0] r_remaining;
  logic               r_refund;
  logic               r_busy;
  logic               r_ready;
  logic [PW-1:0]      r_product;
  logic [CW-1:0]      r_change;
  logic               r_change_strobe;
  logic               r_no_change;
  logic               r_give;
  logic               r_sold_out;

  logic               w_prod_ok;
  logic               w_coin_ok;
  logic [MONEY_W-1:0] w_coin_val;
  logic [MONEY_W:0]   w_credit_sum;
  logic [MONEY_W-1:0] w_credit_add;
  logic [MONEY_W-1:0] w_price;
  logic               w_pick_found;
  logic [CW-1:0]      w_pick_idx;
  logic [MONEY_W-1:0] w_pick_val;

  assign w_prod_ok    = ({1'b0, bus.i_product_code}  < (PW+1)'(N_PRODUCTS));
  assign w_coin_ok    = bus.i_currency_strobe &&
                        ({1'b0, bus.i_currency_code} < (CW+1)'(N_COINS));
  assign w_coin_val   = COIN_TABLE[bus.i_currency_code*MONEY_W +: MONEY_W];
  assign w_credit_sum = {1'b0, r_credit} + {1'b0, w_coin_val};
  // Credit pins at full scale instead of wrapping past it.
  assign w_credit_add = w_credit_sum[MONEY_W] ? '1 : w_credit_sum[MONEY_W-1:0];
  assign w_price      = PRICE_TABLE[r_product*MONEY_W +: MONEY_W];
  assign w_pick_val   = COIN_TABLE[w_pick_idx*MONEY_W +: MONEY_W];

  // Greedy pick: the scan runs upward so the largest usable denomination wins.
  always_comb begin
    // NOTE: defaults before the loop keep every path assigned, so no latch is inferred.
    w_pick_found = 1'b0;
    w_pick_idx   = '0;
    for (int i = 0; i < N_COINS; i++) begin
      if (COIN_TABLE[i*MONEY_W +: MONEY_W] <= r_remaining && r_inv[i] != '0) begin
        w_pick_found = 1'b1;
        w_pick_idx   = CW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_state         <= S_IDLE;
      r_credit        <= '0;
      r_remaining     <= '0;
      r_refund        <= 1'b0;
      r_busy          <= 1'b0;
      r_ready         <= 1'b0;
      r_product       <= '0;
      r_change        <= '0;
      r_change_strobe <= 1'b0;
      r_no_change     <= 1'b0;
      r_give          <= 1'b0;
      r_sold_out      <= 1'b0;
      // NOTE: the counter arrays are machine state, not scratch storage, so reset must restore them.
      for (int i = 0; i < N_PRODUCTS; i++) r_stock[i] <= COUNT_W'(INIT_STOCK);
      for (int i = 0; i < N_COINS; i++)    r_inv[i]   <= COUNT_W'(INIT_COIN_CNT);
    end else begin
      // NOTE: non-blocking defaults; a later assignment in the case below wins for this cycle.
      r_change_strobe <= 1'b0;
      r_no_change     <= 1'b0;
      r_give          <= 1'b0;
      r_sold_out      <= 1'b0;

      unique case (r_state)
        S_IDLE: begin
          r_credit <= '0;
          if (bus.i_product_strobe && w_prod_ok) begin
            if (r_stock[bus.i_product_code] != '0) begin
              r_product <= bus.i_product_code;
              r_busy    <= 1'b1;
              r_ready   <= 1'b1;
              r_state   <= S_COLLECT;
            end else begin
              r_sold_out <= 1'b1;
            end
          end
        end

        S_COLLECT: begin
          if (w_coin_ok) begin
            r_credit <= w_credit_add;
            if (r_inv[bus.i_currency_code] != '1)
              r_inv[bus.i_currency_code] <= r_inv[bus.i_currency_code] + COUNT_W'(1);
          end
          // A coin landing with cancel is banked first, then refunded with the rest.
          if (bus.i_cancel) begin
            r_refund    <= 1'b1;
            r_remaining <= w_coin_ok ? w_credit_add : r_credit;
            r_ready     <= 1'b0;
            r_state     <= S_CHANGE;
          end else if (w_coin_ok) begin
            r_ready <= 1'b0;
            r_state <= S_EVAL;
          end
        end

        S_EVAL: begin
          if (r_credit >= w_price) begin
            r_remaining <= r_credit - w_price;
            r_refund    <= 1'b0;
            r_state     <= S_CHANGE;
          end else begin
            r_ready <= 1'b1;
            r_state <= S_COLLECT;
          end
        end

        S_CHANGE: begin
          if (r_remaining == '0) begin
            r_state <= r_refund ? S_DONE : S_VEND;
          end else if (w_pick_found) begin
            r_change              <= w_pick_idx;
            r_change_strobe       <= 1'b1;
            r_inv[w_pick_idx]     <= r_inv[w_pick_idx] - COUNT_W'(1);
            r_remaining           <= r_remaining - w_pick_val;
          end else begin
            // Shortfall is forfeited; the customer still gets the product on a sale.
            r_no_change <= 1'b1;
            r_remaining <= '0;
            r_state     <= r_refund ? S_DONE : S_VEND;
          end
        end

        S_VEND: begin
          r_give <= 1'b1;
          if (r_stock[r_product] != '0)
            r_stock[r_product] <= r_stock[r_product] - COUNT_W'(1);
          r_state <= S_DONE;
        end

        S_DONE: begin
          r_busy   <= 1'b0;
          r_credit <= '0;
          r_refund <= 1'b0;
          r_state  <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_busy             = r_busy;
  assign bus.o_ready_to_receive = r_ready;
  assign bus.o_credit           = r_credit;
  assign bus.o_product          = r_product;
  assign bus.o_change           = r_change;
  assign bus.o_change_strobe    = r_change_strobe;
  assign bus.o_no_change        = r_no_change;
  assign bus.o_give_strobe      = r_give;
  assign bus.o_sold_out         = r_sold_out;

endmodule

// File: tb/tb_vending_machine_gen2.sv
// Bench for vending_machine_gen2: a stocked unit and an empty-hopper, single-stock unit,
// driven by directed scenarios and random transactions against a transaction-level model.
module tb_vending_machine_gen2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ps, cs, cn;
  logic [2:0] pc, cc;
  int         tgt;

  always #5 clk = ~clk;

  vending_machine_gen2_if #(.PW(3), .CW(3), .MONEY_W(16)) bus0 ();
  vending_machine_gen2_if #(.PW(3), .CW(3), .MONEY_W(16)) bus1 ();

  assign bus0.i_product_code    = pc;
  assign bus0.i_currency_code   = cc;
  assign bus0.i_product_strobe  = ps && (tgt == 0);
  assign bus0.i_currency_strobe = cs && (tgt == 0);
  assign bus0.i_cancel          = cn && (tgt == 0);
  assign bus1.i_product_code    = pc;
  assign bus1.i_currency_code   = cc;
  assign bus1.i_product_strobe  = ps && (tgt == 1);
  assign bus1.i_currency_strobe = cs && (tgt == 1);
  assign bus1.i_cancel          = cn && (tgt == 1);

  vending_machine_gen2 u_dut (.clk(clk), .i_rst_n(rst_n), .bus(bus0));
  vending_machine_gen2 #(.INIT_COIN_CNT(0), .INIT_STOCK(1)) u_dut_lean (
    .clk(clk), .i_rst_n(rst_n), .bus(bus1));

  logic        m_busy, m_ready, m_chg_stb, m_nochg, m_give, m_so;
  logic [15:0] m_credit;
  logic [2:0]  m_product, m_chg;
  assign m_busy    = tgt == 1 ? bus1.o_busy             : bus0.o_busy;
  assign m_ready   = tgt == 1 ? bus1.o_ready_to_receive : bus0.o_ready_to_receive;
  assign m_credit  = tgt == 1 ? bus1.o_credit           : bus0.o_credit;
  assign m_product = tgt == 1 ? bus1.o_product          : bus0.o_product;
  assign m_chg     = tgt == 1 ? bus1.o_change           : bus0.o_change;
  assign m_chg_stb = tgt == 1 ? bus1.o_change_strobe    : bus0.o_change_strobe;
  assign m_nochg   = tgt == 1 ? bus1.o_no_change        : bus0.o_no_change;
  assign m_give    = tgt == 1 ? bus1.o_give_strobe      : bus0.o_give_strobe;
  assign m_so      = tgt == 1 ? bus1.o_sold_out         : bus0.o_sold_out;

  // Event log of the selected unit, sampled on the falling edge.
  int cyc = 0;
  int mon_chg[$];
  int mon_chg_cyc[$];
  int mon_nochg = 0, mon_give = 0, mon_so = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (m_chg_stb) begin
      mon_chg.push_back(int'(m_chg));
      mon_chg_cyc.push_back(cyc);
    end
    if (m_nochg) mon_nochg++;
    if (m_give)  mon_give++;
    if (m_so)    mon_so++;
  end

  // Reference model: coin values and prices from the published tables, counters per unit.
  int cv[8] = '{1, 5, 10, 25, 50, 100, 200, 500};
  int st[2][8];
  int inv[2][8];
  int n_cmp = 0, n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      st[0][i] = 10; inv[0][i] = 100;
      st[1][i] = 1;  inv[1][i] = 0;
    end
  endtask

  task automatic pulse(input bit a_ps, input int a_pc, input bit a_cs, input int a_cc, input bit a_cn);
    ps = a_ps; pc = 3'(a_pc); cs = a_cs; cc = 3'(a_cc); cn = a_cn;
    @(posedge clk); #1;
    ps = 1'b0; cs = 1'b0; cn = 1'b0;
  endtask

  task automatic wait_ready(output bit ok);
    int n = 0;
    while (!m_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    ok = m_ready;
    if (!ok) check("ready_timeout", 0, 1);
  endtask

  // One complete customer transaction; cancel at coin slot cancel_at (with that coin if cwc).
  task automatic run_txn(input int p, input int ncoins, input int coins[16],
                         input int cancel_at, input bit cwc, input bit stray);
    int  b_chg, b_nochg, b_give, b_so, credit, rem, price, c, n;
    bit  refund, settled, ok, nochg, cancel_now;
    int  exp_q[$];
    b_chg = mon_chg.size(); b_nochg = mon_nochg; b_give = mon_give; b_so = mon_so;
    if (stray && $urandom_range(0, 2) == 0) pulse(0, 0, 1, $urandom_range(0, 7), 0);
    pulse(1, p, 0, 0, 0);
    if (st[tgt][p] == 0) begin
      check("sold_out_busy", m_busy, 0);
      @(posedge clk); #1;
      check("sold_out_pulse", mon_so - b_so, 1);
      check("sold_out_no_give", mon_give - b_give, 0);
      return;
    end
    check("sel_busy", m_busy, 1);
    check("sel_ready", m_ready, 1);
    check("sel_product", m_product, p);
    check("sel_credit", m_credit, 0);
    price = 100 + 50 * p; credit = 0; rem = 0; refund = 0; settled = 0;
    for (int k = 0; k <= ncoins && !settled; k++) begin
      wait_ready(ok);
      if (!ok) return;
      if (k > 0) check("credit", m_credit, credit);
      if (stray && $urandom_range(0, 3) == 0) pulse(1, $urandom_range(0, 7), 0, 0, 0);
      if (k == ncoins || (k == cancel_at && !cwc)) begin
        pulse(0, 0, 0, 0, 1);
        refund = 1; rem = credit; settled = 1;
      end else begin
        c = coins[k];
        cancel_now = (k == cancel_at);
        pulse(0, 0, 1, c, cancel_now);
        credit = (credit + cv[c] > 65535) ? 65535 : credit + cv[c];
        if (inv[tgt][c] < 255) inv[tgt][c]++;
        if (cancel_now)           begin refund = 1; rem = credit;         settled = 1; end
        else if (credit >= price) begin            rem = credit - price; settled = 1; end
      end
    end
    nochg = 0;
    while (rem > 0 && !nochg) begin
      c = -1;
      for (int i = 7; i >= 0 && c < 0; i--)
        if (cv[i] <= rem && inv[tgt][i] > 0) c = i;
      if (c < 0) nochg = 1;
      else begin
        exp_q.push_back(c); inv[tgt][c]--; rem -= cv[c];
      end
    end
    if (!refund) st[tgt][p]--;
    n = 0;
    while (m_busy && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("busy_released", m_busy, 0);
    check("chg_count", mon_chg.size() - b_chg, exp_q.size());
    for (int i = 0; i < exp_q.size() && b_chg + i < mon_chg.size(); i++)
      check("chg_coin", mon_chg[b_chg + i], exp_q[i]);
    check("no_change", mon_nochg - b_nochg, nochg ? 1 : 0);
    check("give", mon_give - b_give, refund ? 0 : 1);
    check("end_product", m_product, p);
    check("end_credit", m_credit, 0);
    check("end_ready", m_ready, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  coins[16];
    int  b, n;
    bit  ok;
    bit  g[6], bz[6];
    tgt = 0; ps = 0; cs = 0; cn = 0; pc = '0; cc = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int t = 0; t < 2; t++) begin
      tgt = t; #1;
      check("rst_busy", m_busy, 0);
      check("rst_ready", m_ready, 0);
      check("rst_credit", m_credit, 0);
      check("rst_product", m_product, 0);
    end
    tgt = 0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Exact payment with latency check: coin driven after edge N.
    b = mon_give;
    pulse(1, 0, 0, 0, 0);
    wait_ready(ok);
    cs = 1'b1; cc = 3'd5;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      cs = 1'b0;
      @(negedge clk);
      g[k] = m_give; bz[k] = m_busy;
    end
    @(posedge clk); #1;
    inv[0][5]++; st[0][0]--;
    check("t1_give_n3", g[3], 0);
    check("t1_give_n4", g[4], 1);
    check("t1_busy_n4", bz[4], 1);
    check("t1_busy_n5", bz[5], 0);
    check("t1_give_count", mon_give - b, 1);
    check("t1_product", m_product, 0);

    // Change 350 from a 500 coin: 200, 100, 50 on consecutive cycles.
    coins = '{default: 0}; coins[0] = 7;
    b = mon_chg.size();
    run_txn(1, 1, coins, -1, 0, 0);
    if (mon_chg.size() >= b + 3) begin
      check("t2_c0", mon_chg[b], 6);
      check("t2_c1", mon_chg[b + 1], 5);
      check("t2_c2", mon_chg[b + 2], 4);
      check("t2_consec_a", mon_chg_cyc[b + 1] - mon_chg_cyc[b], 1);
      check("t2_consec_b", mon_chg_cyc[b + 2] - mon_chg_cyc[b + 1], 1);
    end else check("t2_len", mon_chg.size() - b, 3);

    // Cancel after 150 toward a 250 product.
    coins = '{default: 0}; coins[0] = 5; coins[1] = 4;
    b = mon_chg.size();
    run_txn(3, 2, coins, 2, 0, 0);
    if (mon_chg.size() >= b + 2) begin
      check("t4_c0", mon_chg[b], 5);
      check("t4_c1", mon_chg[b + 1], 4);
    end else check("t4_len", mon_chg.size() - b, 2);

    // Empty hopper: shortfall forfeited, then refund using the banked 500s, then sold out.
    tgt = 1; #1;
    coins = '{default: 0}; coins[0] = 7;
    b = mon_nochg;
    run_txn(0, 1, coins, -1, 0, 0);
    check("t3_no_change", mon_nochg - b, 1);
    b = mon_chg.size();
    run_txn(1, 1, coins, 0, 1, 0);
    if (mon_chg.size() > b) check("t3_refund_coin", mon_chg[b], 7);
    else check("t3_refund_len", mon_chg.size() - b, 1);
    b = mon_so;
    run_txn(0, 1, coins, -1, 0, 0);
    check("t5_sold_out", mon_so - b, 1);
    check("t5_busy", m_busy, 0);

    // Reset while paying change.
    tgt = 0; #1;
    b = mon_chg.size();
    pulse(1, 1, 0, 0, 0);
    wait_ready(ok);
    pulse(0, 0, 1, 7, 0);
    n = 0;
    while (mon_chg.size() == b && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("t6_in_change", mon_chg.size() > b, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("t6_busy", m_busy, 0);
    check("t6_ready", m_ready, 0);
    check("t6_credit", m_credit, 0);
    check("t6_product", m_product, 0);
    check("t6_change", m_chg, 0);
    check("t6_strobes", {m_chg_stb, m_nochg, m_give, m_so}, 0);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    coins = '{default: 0}; coins[0] = 7;
    run_txn(1, 1, coins, -1, 0, 0);

    // Random transactions, mostly on the stocked unit.
    for (int t = 0; t < 50; t++) begin
      int p, nc, ca;
      tgt = (t % 5 == 4) ? 1 : 0; #1;
      p  = $urandom_range(0, 7);
      nc = $urandom_range(1, 12);
      for (int i = 0; i < 16; i++) coins[i] = $urandom_range(0, 7);
      ca = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nc) : -1;
      run_txn(p, nc, coins, ca, 1'($urandom_range(0, 1)), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
